// File: rtl/syn_current.sv
// Synaptic current stage: latches spikes between ticks, holds per-input weights,
// and produces a leaky saturating current on each tick. Optional macro: SYN_INHIB_EN.
module syn_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         spike,
    input  logic         tick,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] contrib
);
    logic         pending;
    logic [W-1:0] weight;

    // A spike coincident with tick is consumed by that update, never carried.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            weight  <= '0;
        end else begin
            if (tick)       pending <= 1'b0;
            else if (spike) pending <= 1'b1;
            if (wr_en)      weight  <= wr_data;
        end
    end

    assign contrib = (pending | spike) ? weight : '0;
endmodule

module syn_current #(
    parameter int N_IN        = 4,
    parameter int W           = 8,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN-1:0]         spikes_in,
`ifdef SYN_INHIB_EN
    input  logic [N_IN-1:0]         inhib,
`endif
    input  logic                    tick,
    input  logic                    wr_en,
    input  logic [$clog2(N_IN)-1:0] wr_addr,
    input  logic [W-1:0]            wr_data,
    output logic [W-1:0]            current,
    output logic                    current_valid,
    output logic                    sat
);
    localparam int AW = $clog2(N_IN);
    localparam int SW = W + AW + 1;

    logic [N_IN-1:0][W-1:0] contrib;
    logic [N_IN-1:0]        lane_we;
    logic [W-1:0]           decayed;
    logic [W-1:0]           cur_nxt;
    logic                   over;

    // Addresses beyond N_IN-1 match no lane and are dropped.
    for (genvar g = 0; g < N_IN; g++) begin : g_dec
        assign lane_we[g] = wr_en && (wr_addr == AW'(g));
    end

    syn_lane #(.W(W)) u_lane [N_IN-1:0] (
        .clk     (clk),
        .reset   (reset),
        .spike   (spikes_in),
        .tick    (tick),
        .wr_en   (lane_we),
        .wr_data (wr_data),
        .contrib (contrib)
    );

    assign decayed = current - (current >> DECAY_SHIFT);

`ifdef SYN_INHIB_EN
    logic [SW-1:0]        sum_exc, sum_inh;
    logic signed [SW:0]   nxt_s;
    logic                 neg;

    always_comb begin
        sum_exc = '0;
        sum_inh = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (inhib[i]) sum_inh = sum_inh + SW'(contrib[i]);
            else          sum_exc = sum_exc + SW'(contrib[i]);
        end
        nxt_s = $signed({1'b0, SW'(decayed)}) + $signed({1'b0, sum_exc})
              - $signed({1'b0, sum_inh});
        neg   = nxt_s[SW];
        over  = !neg && (nxt_s[SW-1:W] != '0);
        if (neg)       cur_nxt = '0;
        else if (over) cur_nxt = '1;
        else           cur_nxt = nxt_s[W-1:0];
    end
`else
    logic [SW-1:0] sum_exc, nxt;

    always_comb begin
        sum_exc = '0;
        for (int i = 0; i < N_IN; i++)
            sum_exc = sum_exc + SW'(contrib[i]);
        nxt     = SW'(decayed) + sum_exc;
        over    = nxt[SW-1:W] != '0;
        cur_nxt = over ? '1 : nxt[W-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            current       <= '0;
            current_valid <= 1'b0;
            sat           <= 1'b0;
        end else begin
            current_valid <= tick;
            if (tick) begin
                current <= cur_nxt;
                sat     <= over;
            end
        end
    end
endmodule

// File: doc/syn_current.md
Name: syn_current

Overview:
Synaptic current stage that sits directly upstream of the LIF neuron and drives its 8-bit current input. It latches presynaptic spikes between timestep ticks and holds a per-input programmable weight register file. On each tick it produces a leaky, saturating synaptic current: an exponential decay plus the summed weights of the inputs that spiked.

Parameters:
N_IN, 4, number of presynaptic spike inputs (2..16)
W, 8, width of weights and current output
DECAY_SHIFT, 2, leak per tick equals I >> DECAY_SHIFT (1..W-1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
spikes_in  input  N_IN  presynaptic spike pulses, any width, bit i = input i
tick  input  1  timestep strobe, one-cycle pulse
wr_en  input  1  weight write enable
wr_addr  input  clog2(N_IN)  weight index
wr_data  input  W  unsigned weight value
current  output  W  synaptic current to neuron
current_valid  output  1  one-cycle pulse: current updated this cycle
sat  output  1  current clamped at max on last update

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high, and takes priority over tick, wr_en and spikes. On reset: current=0, current_valid=0, sat=0, all weights=0, pending=0.
- pending[N_IN-1:0] register: bit i is set on any cycle with spikes_in[i]=1. Multiple spikes on one input between ticks count once.
- On a cycle with tick=1, the effective set is eff = pending | spikes_in. A spike on the same cycle as tick is included in this update and is not carried forward. pending is cleared that edge.
- Update computed at the tick edge:
  - S = sum of weight[i] for each i with eff[i]=1, computed at width W+clog2(N_IN)+1.
  - I_next = current - (current >> DECAY_SHIFT) + S.
  - If I_next > 2^W-1: current <= 2^W-1 and sat <= 1. Otherwise current <= I_next and sat <= 0.
- Latency: the new current and current_valid=1 appear in the cycle after tick (registered). current_valid is low otherwise. sat is updated only on tick and holds between ticks.
- current holds between ticks; decay is applied only on tick.
- Weight write: on wr_en=1, weight[wr_addr] <= wr_data at the edge.
  - wr_addr >= N_IN is ignored.
  - If wr_en and tick occur in the same cycle, the update uses the old weight and the new weight is stored that edge.
- Back-to-back ticks are legal: each tick performs one full update.
- Zero current and no spikes: current stays 0, current_valid still pulses.
- Arithmetic is unsigned throughout, and no intermediate truncation occurs before the clamp.

Optional Feature:
SYN_INHIB_EN
- Defined: adds input port inhib[N_IN-1:0]. Input i with inhib[i]=1 is inhibitory.
  - I_next = current - (current >> DECAY_SHIFT) + S_exc - S_inh, computed signed at width W+clog2(N_IN)+2.
  - A result below 0 clamps current to 0. sat=0 in that case.
  - Upper clamp behaviour is unchanged.
- Undefined: no inhib port; all inputs are excitatory exactly as described above.

Test Plan:
(N_IN=4, W=8, DECAY_SHIFT=2)
1. Assert reset 2 cycles, then release -> current=0, current_valid=0, sat=0. A tick with spikes_in=4'b1111 -> current stays 0 (weights reset to 0), with a current_valid pulse.
2. Write w0=40; spikes_in[0] pulse with tick -> next cycle current=40, current_valid=1. Tick with no spikes -> 30. Another tick -> 23.
3. All weights=100; spikes_in=4'b1111 with tick -> current=255, sat=1. Repeat -> 255, sat=1. Tick with no spikes -> 192, sat=0.
4. w1=20; spikes_in[1] one-cycle pulse at cycle 3, tick at cycle 7 -> current=20. Next tick with no spikes -> 15 (pending was cleared).
5. w2=10, current=0. Same cycle: wr_en with addr 2, data 50, spikes_in[2], tick -> current=10. Next tick with spikes_in[2] -> 10-2+50=58.
6. Build current to 150, then assert reset on the same cycle as tick and spikes -> current=0, valid=0, sat=0. After release, a tick with spikes_in=4'b1111 -> current=0 (weights cleared).
